// File: rtl/crc_serial_engine_if.sv
// Bit-stream and shift-out signal bundle for crc_serial_engine.
// Latency: none, wires only.
// Backpressure: none; inputs are valid-qualified, outputs are flagged by bitout_valid/shift_done.
interface crc_serial_engine_if #(
  parameter int WIDTH = 5
);

  // Inputs to the engine
  logic             clear;
  logic             bitin;
  logic             bitin_valid;
  logic             shift_start;

  // Outputs from the engine
  logic [WIDTH-1:0] crc;
  logic             bitout;
  logic             bitout_valid;
  logic             shift_done;
  logic             busy;
  logic             err;
  logic             crc_ok;

  // Producer/consumer side (bit source, backscatter encoder, frame checker)
  modport master (
    output clear,
    output bitin,
    output bitin_valid,
    output shift_start,
    input  crc,
    input  bitout,
    input  bitout_valid,
    input  shift_done,
    input  busy,
    input  err,
    input  crc_ok
  );

  // CRC engine side
  modport slave (
    input  clear,
    input  bitin,
    input  bitin_valid,
    input  shift_start,
    output crc,
    output bitout,
    output bitout_valid,
    output shift_done,
    output busy,
    output err,
    output crc_ok
  );

endinterface

// File: rtl/crc_serial_engine.sv
// Serial CRC generator/checker (CRC-5 Gen2 or CRC-16/CCITT) with MSB-first shift-out; CRC_CHECK_EN builds the residue comparator.
// Latency: crc updates one edge after an accepted bit; bitout_valid rises one edge after shift_start, lasts WIDTH cycles, then shift_done.
// Backpressure: none; bitin_valid/shift_start arriving while busy are dropped and latch the sticky err flag.
module crc_serial_engine #(
  parameter int             WIDTH      = 5,
  parameter logic [WIDTH-1:0] POLY     = 5'b01001,
  parameter logic [WIDTH-1:0] PRESET   = 5'b01001,
  parameter bit             INVERT_OUT = 1'b0,
  parameter logic [WIDTH-1:0] RESIDUE  = 5'b00000
) (
  input  logic                 crcinclk,
  input  logic                 reset,
  crc_serial_engine_if.slave   bus
);

  // Counter only has to reach WIDTH-1 (at most 31).
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_upd;
  logic [WIDTH-1:0] crc_nxt;
  logic [WIDTH-1:0] out_sr;
  logic [WIDTH-1:0] out_sr_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             err_q;
  logic             err_nxt;
  logic             fb;
  logic             req_any;

  // One LFSR step of the current register with the incoming bit.
  always_comb begin
    fb      = bus.bitin ^ crc_q[WIDTH-1];
    crc_upd = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  assign req_any = bus.bitin_valid | bus.shift_start;

  // Next-state and datapath decisions; clear overrides everything.
  always_comb begin
    state_nxt  = state;
    crc_nxt    = crc_q;
    out_sr_nxt = out_sr;
    cnt_nxt    = cnt;
    err_nxt    = err_q;

    if (bus.clear) begin
      state_nxt  = IDLE;
      crc_nxt    = PRESET;
      out_sr_nxt = '0;
      cnt_nxt    = '0;
      err_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.bitin_valid) begin
            crc_nxt = crc_upd;
          end
          // The snapshot includes a bit accepted on this same edge.
          if (bus.shift_start) begin
            state_nxt  = SHIFT;
            out_sr_nxt = INVERT_OUT ? ~crc_nxt : crc_nxt;
            cnt_nxt    = CNT_LAST;
          end
        end

        SHIFT: begin
          out_sr_nxt = {out_sr[WIDTH-2:0], 1'b0};
          if (cnt == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
          if (req_any) begin
            err_nxt = 1'b1;
          end
        end

        DONE: begin
          state_nxt = IDLE;
          if (req_any) begin
            err_nxt = 1'b1;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State register; reset aborts any shift in progress immediately.
  always_ff @(posedge crcinclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // CRC register, shift-out register, bit counter and sticky error flag.
  always_ff @(posedge crcinclk or posedge reset) begin
    if (reset) begin
      crc_q  <= PRESET;
      out_sr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      crc_q  <= crc_nxt;
      out_sr <= out_sr_nxt;
      cnt    <= cnt_nxt;
      err_q  <= err_nxt;
    end
  end

  // Status outputs decode only registered state, never the inputs.
  assign bus.crc          = crc_q;
  assign bus.bitout_valid = (state == SHIFT);
  assign bus.bitout       = (state == SHIFT) & out_sr[WIDTH-1];
  assign bus.shift_done   = (state == DONE);
  assign bus.busy         = (state != IDLE);
  assign bus.err          = err_q;

`ifdef CRC_CHECK_EN
  // Good frame (data followed by its own CRC) leaves the register at RESIDUE.
  assign bus.crc_ok = (crc_q == RESIDUE);
`else
  assign bus.crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: one CRC-5 and one CRC-16 instance driven by directed vectors.
// The reference model recomputes each CRC by polynomial long division over the whole
// message received since the last reset/clear, and tracks the shift-out by cycle count.
module tb_crc_serial_engine;

  localparam logic [4:0]  P5   = 5'b01001;
  localparam logic [4:0]  PR5  = 5'b01001;
  localparam logic [4:0]  R5   = 5'b00000;
  localparam logic [15:0] P16  = 16'h1021;
  localparam logic [15:0] PR16 = 16'hFFFF;
  localparam logic [15:0] R16  = 16'h1D0F;
`ifdef CRC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic crcinclk = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  bit   cmp_en   = 1'b0;

  crc_serial_engine_if #(.WIDTH(5))  if5();
  crc_serial_engine_if #(.WIDTH(16)) if16();

  crc_serial_engine #(.WIDTH(5), .POLY(P5), .PRESET(PR5), .INVERT_OUT(1'b0), .RESIDUE(R5)) u5 (
    .crcinclk(crcinclk), .reset(reset), .bus(if5));

  crc_serial_engine #(.WIDTH(16), .POLY(P16), .PRESET(PR16), .INVERT_OUT(1'b1), .RESIDUE(R16)) u16 (
    .crcinclk(crcinclk), .reset(reset), .bus(if16));

  always #5 crcinclk = ~crcinclk;

  // Remainder of (preset*x^n + M(x)*x^w) mod G(x), G = x^w + poly.
  function automatic logic [31:0] crc_model(input int w, input logic [31:0] poly,
                                            input logic [31:0] preset, input bit q[$]);
    bit d[];
    int n;
    logic [31:0] r;
    n = q.size();
    d = new[n + w];
    for (int i = 0; i < n + w; i++) d[i] = (i < n) ? q[i] : 1'b0;
    for (int i = 0; i < w; i++) d[i] = d[i] ^ preset[w-1-i];
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin
        d[i] = 1'b0;
        for (int j = 1; j <= w; j++) d[i+j] = d[i+j] ^ poly[w-j];
      end
    end
    r = '0;
    for (int i = 0; i < w; i++) r = {r[30:0], d[n+i]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: message bits, cycles since shift_start (0 = idle), shifted value, sticky error.
  bit q5[$];
  bit q16[$];
  int k5 = 0;
  int k16 = 0;
  logic [31:0] sv5 = '0;
  logic [31:0] sv16 = '0;
  bit e5 = 1'b0;
  bit e16 = 1'b0;

  always @(posedge crcinclk or posedge reset) begin
    if (reset || if5.clear) begin
      q5.delete(); k5 <= 0; sv5 <= '0; e5 <= 1'b0;
    end else if (k5 == 0) begin
      if (if5.bitin_valid) q5.push_back(if5.bitin);
      if (if5.shift_start) begin
        k5  <= 1;
        sv5 <= crc_model(5, 32'(P5), 32'(PR5), q5);
      end
    end else begin
      if (if5.bitin_valid || if5.shift_start) e5 <= 1'b1;
      k5 <= (k5 == 6) ? 0 : k5 + 1;
    end
  end

  always @(posedge crcinclk or posedge reset) begin
    if (reset || if16.clear) begin
      q16.delete(); k16 <= 0; sv16 <= '0; e16 <= 1'b0;
    end else if (k16 == 0) begin
      if (if16.bitin_valid) q16.push_back(if16.bitin);
      if (if16.shift_start) begin
        k16  <= 1;
        sv16 <= crc_model(16, 32'(P16), 32'(PR16), q16) ^ 32'h0000_FFFF;
      end
    end else begin
      if (if16.bitin_valid || if16.shift_start) e16 <= 1'b1;
      k16 <= (k16 == 17) ? 0 : k16 + 1;
    end
  end

  task automatic cmp_dut(input string t, input int w, input logic [31:0] pl, input logic [31:0] pr,
                         input logic [31:0] rs, input bit q[$], input int k, input logic [31:0] sv,
                         input bit e, input logic [31:0] a_crc, input logic a_bo, input logic a_bov,
                         input logic a_sd, input logic a_by, input logic a_er, input logic a_ok);
    logic [31:0] c;
    bit vld;
    c   = crc_model(w, pl, pr, q);
    vld = (k >= 1) && (k <= w);
    chk({t, ".crc"},          a_crc, c);
    chk({t, ".crc_ok"},       32'(a_ok), 32'(CHK && (c == rs)));
    chk({t, ".bitout_valid"}, 32'(a_bov), 32'(vld));
    chk({t, ".bitout"},       32'(a_bo), vld ? 32'(sv[w-k]) : 32'd0);
    chk({t, ".shift_done"},   32'(a_sd), 32'(k == w + 1));
    chk({t, ".busy"},         32'(a_by), 32'(k != 0));
    chk({t, ".err"},          32'(a_er), 32'(e));
  endtask

  // Single compare process, away from the active edge.
  always @(negedge crcinclk) begin
    if (cmp_en && !reset) begin
      cmp_dut("m5", 5, 32'(P5), 32'(PR5), 32'(R5), q5, k5, sv5, e5,
              32'(if5.crc), if5.bitout, if5.bitout_valid, if5.shift_done, if5.busy, if5.err, if5.crc_ok);
      cmp_dut("m16", 16, 32'(P16), 32'(PR16), 32'(R16), q16, k16, sv16, e16,
              32'(if16.crc), if16.bitout, if16.bitout_valid, if16.shift_done, if16.busy, if16.err, if16.crc_ok);
    end
  end

  task automatic drv(input int s, input logic c, input logic b, input logic v, input logic st);
    if (s == 0) begin
      if5.clear = c; if5.bitin = b; if5.bitin_valid = v; if5.shift_start = st;
    end else begin
      if16.clear = c; if16.bitin = b; if16.bitin_valid = v; if16.shift_start = st;
    end
  endtask

  task automatic pulse(input int s, input logic c, input logic b, input logic v, input logic st);
    drv(s, c, b, v, st);
    @(negedge crcinclk);
    drv(s, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed(input int s, input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drv(s, 1'b0, d[i], 1'b1, 1'b0);
      @(negedge crcinclk);
    end
    drv(s, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic collect(input int s, input int w, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < w; i++) begin
      v = {v[30:0], (s == 0) ? if5.bitout : if16.bitout};
      @(negedge crcinclk);
    end
  endtask

  logic [31:0] v;

  initial begin
    drv(0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge crcinclk);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    chk("rst5.crc", 32'(if5.crc), 32'h09);
    chk("rst16.crc", 32'(if16.crc), 32'hFFFF);
    chk("rst5.busy", 32'(if5.busy), 32'd0);
    chk("rst16.err", 32'(if16.err), 32'd0);
    chk("rst5.crc_ok", 32'(if5.crc_ok), 32'd0);

    // Single bit 0, then single bit 1 after a fresh reset (CRC-5)
    feed(0, 32'd0, 1);
    chk("crc5_bit0", 32'(if5.crc), 32'h12);
    reset = 1'b1;
    @(negedge crcinclk);
    reset = 1'b0;
    feed(0, 32'd1, 1);
    chk("crc5_bit1", 32'(if5.crc), 32'h1B);

    // CRC-16: bit 0 then shift-out of complemented register
    feed(1, 32'd0, 1);
    chk("crc16_bit0", 32'(if16.crc), 32'hEFDF);
    pulse(1, 1'b0, 1'b0, 1'b0, 1'b1);
    collect(1, 16, v);
    chk("crc16_shift_seq", v, 32'h1020);
    chk("crc16_shift_done", 32'(if16.shift_done), 32'd1);
    @(negedge crcinclk);
    chk("crc16_idle_after", 32'(if16.busy), 32'd0);

    // Residue: CRC-5 over a frame, then the frame's CRC fed back
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(0, 32'hA5C3, 16);
    pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
    collect(0, 5, v);
    @(negedge crcinclk);
    feed(0, v, 5);
    chk("res5.crc", 32'(if5.crc), 32'h00);
    chk("res5.crc_ok", 32'(if5.crc_ok), 32'(CHK));

    // Residue: CRC-16 with complemented CRC fed back
    pulse(1, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(1, 32'hA5C3, 16);
    pulse(1, 1'b0, 1'b0, 1'b0, 1'b1);
    collect(1, 16, v);
    @(negedge crcinclk);
    feed(1, v, 16);
    chk("res16.crc", 32'(if16.crc), 32'h1D0F);
    chk("res16.crc_ok", 32'(if16.crc_ok), 32'(CHK));

    // Bit accepted on the shift_start edge is part of the shifted value
    pulse(1, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1, 1'b0, 1'b1, 1'b1, 1'b1);
    collect(1, 16, v);
    chk("same_edge_seq", v, 32'h0001);
    @(negedge crcinclk);

    // bitin_valid during SHIFT is dropped and sets sticky err
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("busy_in.crc", 32'(if5.crc), 32'h09);
    chk("busy_in.err", 32'(if5.err), 32'd1);
    repeat (5) @(negedge crcinclk);
    chk("err_sticky.busy", 32'(if5.busy), 32'd0);
    chk("err_sticky.err", 32'(if5.err), 32'd1);
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_clear", 32'(if5.err), 32'd0);

    // clear during SHIFT
    feed(0, 32'h16, 5);
    pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge crcinclk);
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_shift.crc", 32'(if5.crc), 32'h09);
    chk("clr_shift.busy", 32'(if5.busy), 32'd0);
    chk("clr_shift.bov", 32'(if5.bitout_valid), 32'd0);
    chk("clr_shift.err", 32'(if5.err), 32'd0);

    // Asynchronous reset in the middle of a shift
    feed(0, 32'h5, 3);
    pulse(1, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst5.crc", 32'(if5.crc), 32'h09);
    chk("arst5.busy", 32'(if5.busy), 32'd0);
    chk("arst5.bov", 32'(if5.bitout_valid), 32'd0);
    chk("arst5.bitout", 32'(if5.bitout), 32'd0);
    chk("arst16.crc", 32'(if16.crc), 32'hFFFF);
    chk("arst16.busy", 32'(if16.busy), 32'd0);
    chk("arst16.err", 32'(if16.err), 32'd0);
    chk("arst16.done", 32'(if16.shift_done), 32'd0);
    @(negedge crcinclk);
    @(negedge crcinclk);
    reset = 1'b0;
    repeat (2) @(negedge crcinclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
